// File: rtl/riscv_pkg.sv
// Shared constants for the pipelined RISC-V core: ALU opcodes, forward selects
// and default datapath widths.
package riscv_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Combinational RAW-hazard forward selection for the two E-stage source
// operands; the MEM stage wins over WB and x0 is never forwarded.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteM,
  input  logic              regWriteW,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE
);

  function automatic logic [1:0] select_src(input logic [REG_AW-1:0] rs);
    if (regWriteM && (rdM != '0) && (rdM == rs))
      return FWD_MEM;
    else if (regWriteW && (rdW != '0) && (rdW == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign forwardAE = select_src(rs1E);
  assign forwardBE = select_src(rs2E);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register fused with the ALU operand-forwarding muxes.
// Define ALU_FWD_EN to build the forwarding path; otherwise operands come
// straight from the register-file values captured in decode.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallE,
  input  logic              flushE,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   immExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rdD,
  input  logic [2:0]        ALUControlD,
  input  logic              ALUSrcD,
  input  logic              regWriteD,
  input  logic              memWriteD,
  input  logic              jumpD,
  input  logic              branchD,
  input  logic [1:0]        resultSrcD,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic              regWriteM,
  input  logic [REG_AW-1:0] rdM,
  input  logic [XLEN-1:0]   resultW,
  input  logic              regWriteW,
  input  logic [REG_AW-1:0] rdW,
  output logic [XLEN-1:0]   srcA,
  output logic [XLEN-1:0]   srcB,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   writeDataE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   immExtE,
  output logic [REG_AW-1:0] rs1E,
  output logic [REG_AW-1:0] rs2E,
  output logic [REG_AW-1:0] rdE,
  output logic              regWriteE,
  output logic              memWriteE,
  output logic              jumpE,
  output logic              branchE,
  output logic              validE,
  output logic [1:0]        resultSrcE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE
);

  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic            ALUSrcE;

  // Flush wins over stall so a simultaneous request always yields a bubble.
  // NOTE: state is updated with non-blocking assignments and the reset is
  // sampled on the clock edge, so every E register clears on the same edge.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      RD1E        <= '0;
      RD2E        <= '0;
      immExtE     <= '0;
      PCE         <= '0;
      rs1E        <= '0;
      rs2E        <= '0;
      rdE         <= '0;
      ALUControlE <= ALU_ADD;
      ALUSrcE     <= 1'b0;
      regWriteE   <= 1'b0;
      memWriteE   <= 1'b0;
      jumpE       <= 1'b0;
      branchE     <= 1'b0;
      resultSrcE  <= '0;
      validE      <= 1'b0;
    end else if (!stallE) begin
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      immExtE     <= immExtD;
      PCE         <= PCD;
      rs1E        <= rs1D;
      rs2E        <= rs2D;
      rdE         <= rdD;
      ALUControlE <= ALUControlD;
      ALUSrcE     <= ALUSrcD;
      regWriteE   <= regWriteD;
      memWriteE   <= memWriteD;
      jumpE       <= jumpD;
      branchE     <= branchD;
      resultSrcE  <= resultSrcD;
      validE      <= 1'b1;
    end
  end

`ifdef ALU_FWD_EN
  forward_unit #(.REG_AW(REG_AW)) u_forward_unit (
    .rs1E      (rs1E),
    .rs2E      (rs2E),
    .rdM       (rdM),
    .rdW       (rdW),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE)
  );

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    srcA       = RD1E;
    writeDataE = RD2E;
    case (forwardAE)
      FWD_WB:  srcA = resultW;
      FWD_MEM: srcA = ALUResultM;
      default: ;
    endcase
    case (forwardBE)
      FWD_WB:  writeDataE = resultW;
      FWD_MEM: writeDataE = ALUResultM;
      default: ;
    endcase
  end
`else
  // Without forwarding the hazard unit stalls on every RAW dependency.
  logic unused_fwd;
  assign unused_fwd = ^{ALUResultM, resultW, regWriteM, regWriteW, rdM, rdW};

  assign forwardAE  = FWD_RF;
  assign forwardBE  = FWD_RF;
  assign srcA       = RD1E;
  assign writeDataE = RD2E;
`endif

  assign srcB = ALUSrcE ? immExtE : writeDataE;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table followed by
// randomized traffic compared against a behavioural pipeline-register model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stallE, flushE;
  logic [31:0] RD1D, RD2D, immExtD, PCD;
  logic [4:0]  rs1D, rs2D, rdD;
  logic [2:0]  ALUControlD;
  logic        ALUSrcD, regWriteD, memWriteD, jumpD, branchD;
  logic [1:0]  resultSrcD;
  logic [31:0] ALUResultM, resultW;
  logic        regWriteM, regWriteW;
  logic [4:0]  rdM, rdW;
  logic [31:0] srcA, srcB, writeDataE, PCE, immExtE;
  logic [2:0]  ALUControlE;
  logic [4:0]  rs1E, rs2E, rdE;
  logic        regWriteE, memWriteE, jumpE, branchE, validE;
  logic [1:0]  resultSrcE, forwardAE, forwardBE;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE),
    .RD1D(RD1D), .RD2D(RD2D), .immExtD(immExtD), .PCD(PCD),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .ALUControlD(ALUControlD),
    .ALUSrcD(ALUSrcD), .regWriteD(regWriteD), .memWriteD(memWriteD),
    .jumpD(jumpD), .branchD(branchD), .resultSrcD(resultSrcD),
    .ALUResultM(ALUResultM), .regWriteM(regWriteM), .rdM(rdM),
    .resultW(resultW), .regWriteW(regWriteW), .rdW(rdW),
    .srcA(srcA), .srcB(srcB), .ALUControlE(ALUControlE),
    .writeDataE(writeDataE), .PCE(PCE), .immExtE(immExtE),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .jumpE(jumpE),
    .branchE(branchE), .validE(validE), .resultSrcE(resultSrcE),
    .forwardAE(forwardAE), .forwardBE(forwardBE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

`ifdef ALU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst, stall, flush;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu;
    logic        alusrc, regw;
    logic        regw_m, regw_w;
    logic [4:0]  rd_m, rd_w;
    logic [31:0] alu_m, res_w;
    logic        e_valid, e_regw;
    logic [2:0]  e_alu;
    logic [31:0] e_srca, e_srcb, e_wd;
    logic [1:0]  e_fa, e_fb;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic fill_vectors();
    vec_t v;
    // reset twice with busy D inputs
    v = blank(); v.rst = 1; v.rd1 = 32'hAAAA; v.rd2 = 32'hBBBB; v.imm = 32'h10;
    v.rs1 = 7; v.rs2 = 8; v.rd = 9; v.alu = 3'b011; v.regw = 1;
    vecs[0] = v; vecs[1] = v;
    // load 5/7, SUB
    v = blank(); v.rd1 = 5; v.rd2 = 7; v.rs1 = 1; v.rs2 = 2; v.rd = 4; v.alu = 3'b001; v.regw = 1;
    v.e_valid = 1; v.e_regw = 1; v.e_alu = 3'b001; v.e_srca = 5; v.e_srcb = 7; v.e_wd = 7;
    vecs[2] = v;
    // three stall cycles with different D inputs
    for (int i = 3; i < 6; i++) begin
      vecs[i] = v;
      vecs[i].stall = 1; vecs[i].rd1 = 32'h900 + i; vecs[i].rd2 = 32'h300 + i;
      vecs[i].alu = 3'b100; vecs[i].regw = 0;
    end
    // flush + stall together -> bubble
    v = blank(); v.flush = 1; v.stall = 1; v.rd1 = 1; v.regw = 1; v.alu = 3'b101;
    vecs[6] = v;
    // forward priority: MEM beats WB on rs1=3
    v = blank(); v.rd1 = 32'h33; v.rd2 = 32'h55; v.rs1 = 3; v.rs2 = 5; v.rd = 1;
    v.regw_m = 1; v.rd_m = 3; v.alu_m = 32'h11; v.regw_w = 1; v.rd_w = 3; v.res_w = 32'h22;
    v.e_valid = 1; v.e_srca = FWD ? 32'h11 : 32'h33; v.e_fa = FWD ? 2'b10 : 2'b00;
    v.e_srcb = 32'h55; v.e_wd = 32'h55;
    vecs[7] = v;
    // stall, drop regWriteM: WB now wins, re-evaluated while stalled
    v.stall = 1; v.regw_m = 0; v.rd1 = 32'hDEAD;
    v.e_srca = FWD ? 32'h22 : 32'h33; v.e_fa = FWD ? 2'b01 : 2'b00;
    vecs[8] = v;
    // x0 guard and immediate select
    v = blank(); v.rd1 = 32'h44; v.rd2 = 32'h66; v.imm = 32'hFFFFFFFC; v.alusrc = 1;
    v.regw_m = 1; v.rd_m = 0; v.alu_m = 32'h99;
    v.e_valid = 1; v.e_srca = 32'h44; v.e_srcb = 32'hFFFFFFFC; v.e_wd = 32'h66;
    vecs[9] = v;
    // immediate select while rs2 forwards from MEM
    v.rs2 = 6; v.rd_m = 6; v.alu_m = 32'h77;
    v.e_wd = FWD ? 32'h77 : 32'h66; v.e_fb = FWD ? 2'b10 : 2'b00;
    vecs[10] = v;
    // reset during a stall clears the stage
    v = blank(); v.rst = 1; v.stall = 1; v.rd1 = 32'h1234; v.regw = 1;
    vecs[11] = v;
  endtask

  task automatic apply_vector(input vec_t v);
    rst = v.rst; stallE = v.stall; flushE = v.flush;
    RD1D = v.rd1; RD2D = v.rd2; immExtD = v.imm; PCD = 32'h100;
    rs1D = v.rs1; rs2D = v.rs2; rdD = v.rd; ALUControlD = v.alu;
    ALUSrcD = v.alusrc; regWriteD = v.regw; memWriteD = 0; jumpD = 0; branchD = 0;
    resultSrcD = 0;
    regWriteM = v.regw_m; rdM = v.rd_m; ALUResultM = v.alu_m;
    regWriteW = v.regw_w; rdW = v.rd_w; resultW = v.res_w;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        valid;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu;
    logic        alusrc, regw, memw, jump, branch;
    logic [1:0]  rsrc;
  } stage_t;

  stage_t model;

  // Which producer supplies register rs this cycle: 2 = MEM, 1 = WB, 0 = file.
  function automatic logic [1:0] producer(input logic [4:0] rs);
    if (!FWD || rs == 0) return 2'd0;
    if (regWriteM && rdM == rs) return 2'd2;
    if (regWriteW && rdW == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
    logic [1:0] p;
    p = producer(rs);
    return (p == 2) ? ALUResultM : (p == 1) ? resultW : rf;
  endfunction

  task automatic model_edge();
    if (rst || flushE)
      model = '{default: '0};
    else if (!stallE)
      model = '{valid: 1'b1, rd1: RD1D, rd2: RD2D, imm: immExtD, pc: PCD,
                rs1: rs1D, rs2: rs2D, rd: rdD, alu: ALUControlD, alusrc: ALUSrcD,
                regw: regWriteD, memw: memWriteD, jump: jumpD, branch: branchD,
                rsrc: resultSrcD};
  endtask

  task automatic compare_model(input int cyc);
    logic [31:0] wd;
    string       tag;
    tag = $sformatf("rand%0d", cyc);
    wd  = operand(model.rs2, model.rd2);
    check({tag, ".srcA"},    srcA,       operand(model.rs1, model.rd1));
    check({tag, ".wd"},      writeDataE, wd);
    check({tag, ".srcB"},    srcB,       model.alusrc ? model.imm : wd);
    check({tag, ".fwdA"},    32'(forwardAE), 32'(producer(model.rs1)));
    check({tag, ".fwdB"},    32'(forwardBE), 32'(producer(model.rs2)));
    check({tag, ".pc"},      PCE,        model.pc);
    check({tag, ".imm"},     immExtE,    model.imm);
    check({tag, ".idx"},     {17'd0, rs1E, rs2E, rdE}, {17'd0, model.rs1, model.rs2, model.rd});
    check({tag, ".ctrl"},    {22'd0, ALUControlE, validE, regWriteE, memWriteE, jumpE, branchE, resultSrcE},
          {22'd0, model.alu, model.valid, model.regw, model.memw, model.jump, model.branch, model.rsrc});
  endtask

  initial begin
    fill_vectors();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply_vector(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d.valid", i), 32'(validE),      32'(vecs[i].e_valid));
      check($sformatf("v%0d.regw", i),  32'(regWriteE),   32'(vecs[i].e_regw));
      check($sformatf("v%0d.alu", i),   32'(ALUControlE), 32'(vecs[i].e_alu));
      check($sformatf("v%0d.srcA", i),  srcA,             vecs[i].e_srca);
      check($sformatf("v%0d.srcB", i),  srcB,             vecs[i].e_srcb);
      check($sformatf("v%0d.wd", i),    writeDataE,       vecs[i].e_wd);
      check($sformatf("v%0d.fwdA", i),  32'(forwardAE),   32'(vecs[i].e_fa));
      check($sformatf("v%0d.fwdB", i),  32'(forwardBE),   32'(vecs[i].e_fb));
    end

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst         = (c == 0) || ($urandom_range(0, 31) == 0);
      stallE      = ($urandom_range(0, 3) == 0);
      flushE      = ($urandom_range(0, 7) == 0);
      RD1D        = $urandom;
      RD2D        = $urandom;
      immExtD     = $urandom;
      PCD         = $urandom;
      rs1D        = 5'($urandom_range(0, 3));
      rs2D        = 5'($urandom_range(0, 3));
      rdD         = 5'($urandom);
      ALUControlD = 3'($urandom_range(0, 5));
      ALUSrcD     = 1'($urandom);
      regWriteD   = 1'($urandom);
      memWriteD   = 1'($urandom);
      jumpD       = 1'($urandom);
      branchD     = 1'($urandom);
      resultSrcD  = 2'($urandom);
      model_edge();
      @(posedge clk);
      #1;
      // change M/W inputs after the edge so combinational forwarding is
      // exercised against the freshly registered E state
      ALUResultM = $urandom;
      resultW    = $urandom;
      regWriteM  = 1'($urandom);
      regWriteW  = 1'($urandom);
      rdM        = 5'($urandom_range(0, 3));
      rdW        = 5'($urandom_range(0, 3));
      #1;
      compare_model(c);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the pipelined RISC-V core, fused with the operand-forwarding muxes that drive the ALU's `srcA`, `srcB` and `ALUControl` inputs. The block captures decoded operands and control on each clock, honours stall and flush requests from the hazard unit, and resolves RAW hazards by selecting between register-file data, the MEM-stage ALU result and the WB-stage result. It sits directly upstream of the ALU; its registered control outputs also feed the EX/MEM register.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register-index width

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `stallE`  in  1  hold all E-stage registers
- `flushE`  in  1  load a bubble into the E stage
- `RD1D`, `RD2D`, `immExtD`, `PCD`  in  XLEN  decode operands, immediate and PC
- `rs1D`, `rs2D`, `rdD`  in  REG_AW  register indices
- `ALUControlD`  in  3  ALU operation
- `ALUSrcD`, `regWriteD`, `memWriteD`, `jumpD`, `branchD`  in  1  decode control
- `resultSrcD`  in  2  writeback select
- `ALUResultM`  in  XLEN  MEM-stage forward value; `regWriteM` in 1; `rdM` in REG_AW
- `resultW`  in  XLEN  WB-stage forward value; `regWriteW` in 1; `rdW` in REG_AW
- `srcA`, `srcB`  out  XLEN  ALU operands
- `ALUControlE`  out  3  ALU operation
- `writeDataE`, `PCE`, `immExtE`  out  XLEN
- `rs1E`, `rs2E`, `rdE`  out  REG_AW (`rs1E`/`rs2E` go to the hazard unit)
- `regWriteE`, `memWriteE`, `jumpE`, `branchE`, `validE`  out  1
- `resultSrcE`  out  2
- `forwardAE`, `forwardBE`  out  2  active forward selects, for debug and the hazard unit

## Operation
- The register update has the fixed priority `rst` > `flushE` > `stallE` > load.
- On `rst` or `flushE`, every E register is cleared to 0. The cleared state is a bubble: `validE`=0, `regWriteE`=`memWriteE`=`jumpE`=`branchE`=0, `rdE`=0, and `ALUControlE`=000 (ADD).
- On `stallE`, all E registers hold their current values.
- On a load, every D input is captured and `validE` is set to 1.
- Forward select for operand A:
  - 10 (MEM) when `regWriteM` and `rdM`≠0 and `rdM`==`rs1E`.
  - Otherwise 01 (WB) when `regWriteW` and `rdW`≠0 and `rdW`==`rs1E`.
  - Otherwise 00 (register file).
  - MEM always beats WB, and x0 is never forwarded.
- `forwardBE` uses the same rules against `rs2E`.
- `srcA` is the forwarded value of rs1: `RD1E`, `resultW` or `ALUResultM`.
- `writeDataE` is the forwarded value of rs2.
- `srcB` = `ALUSrcE` ? `immExtE` : `writeDataE`.
- Arithmetic: operand values pass through unmodified at XLEN. There is no sign or width conversion here; the ALU treats its operands as signed.

## Timing
- One register stage. D inputs sampled at edge N appear on the E outputs after edge N.
- `srcA`, `srcB`, `writeDataE` and the forward selects are combinational from the E registers and the M/W inputs, with zero added latency. They must settle within the same cycle the ALU uses them.
- The forward path is a combinational loop only if `ALUResultM` depends on `srcA`/`srcB` in the same cycle. It does not, because `ALUResultM` comes from the EX/MEM register.
- Reset values: all registered outputs are 0. `srcA`, `srcB` and `writeDataE` are 0, and `forwardAE`/`forwardBE` are 00, because rs indices of 0 are never forwarded.
- `flushE` and `stallE` asserted together produce a bubble.
- Reset asserted mid-stall clears the stage on the next edge.
- During a stall the forward selects continue to re-evaluate against the current M/W inputs.

## Configuration
- `ALU_FWD_EN` defined: the forwarding logic is present as described.
- `ALU_FWD_EN` undefined:
  - `forwardAE`/`forwardBE` are tied to 00.
  - `srcA`=`RD1E`, `writeDataE`=`RD2E`, and `srcB`=`ALUSrcE` ? `immExtE` : `RD2E`.
  - The hazard unit must then stall on every RAW dependency.

## Structure
- Shared package `riscv_pkg` holds:
  - ALU opcode constants: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101.
  - Forward-select constants: FWD_RF 00, FWD_WB 01, FWD_MEM 10.
  - `XLEN` and `REG_AW` defaults.
- Sub-module `forward_unit` is combinational. It takes `rs1E`, `rs2E`, `rdM`, `rdW`, `regWriteM` and `regWriteW`, and produces `forwardAE`/`forwardBE`. It is instantiated only under `ALU_FWD_EN`.

## Test plan
- Reset: hold `rst` 2 cycles with D inputs nonzero -> all E outputs 0, `validE`=0, `srcA`=`srcB`=0.
- Load then stall: load `RD1D`=5, `RD2D`=7, `ALUControlD`=001 -> `srcA`=5, `srcB`=7 after one edge. Then assert `stallE` for 3 cycles while changing D inputs -> outputs unchanged.
- Flush and stall: assert `flushE` and `stallE` together -> `validE`=0, `regWriteE`=0, `ALUControlE`=000.
- Forward priority: `rs1E`=3, `rdM`=`rdW`=3, `regWriteM`=`regWriteW`=1, `ALUResultM`=0x11, `resultW`=0x22 -> `forwardAE`=10, `srcA`=0x11. Drop `regWriteM` -> `forwardAE`=01, `srcA`=0x22.
- x0 guard and immediate select:
  - `rs2E`=0, `rdM`=0, `regWriteM`=1 -> `forwardBE`=00.
  - `ALUSrcE`=1, `immExtE`=0xFFFFFFFC -> `srcB`=0xFFFFFFFC while `writeDataE` still forwards rs2.
- Without `ALU_FWD_EN`: repeat the forward-priority scenario -> `forwardAE`=00 and `srcA`=`RD1E`.
